// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one program ROM between the CPU fetch port and
// the debug/monitor port. Each read runs IDLE -> ACCESS -> DONE: rom_ce_bar is
// held low for AccessCycles cycles, the data is captured into rd_data, and the
// granted requester gets a one-cycle valid pulse. All outputs are registered.
// Build option: define ROM_ARB_RR_EN for round-robin arbitration on ties;
// otherwise the CPU has fixed priority.
module rom_access_arbiter #(
  parameter int WordSize     = 8,
  parameter int AddressSize  = 4,
  parameter int AccessCycles = 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   cpu_req,
  input  logic [AddressSize-1:0] cpu_addr,
  output logic                   cpu_gnt,
  output logic                   cpu_valid,
  input  logic                   dbg_req,
  input  logic [AddressSize-1:0] dbg_addr,
  output logic                   dbg_gnt,
  output logic                   dbg_valid,
  output logic [WordSize-1:0]    rd_data,
  output logic                   rom_ce_bar,
  output logic [AddressSize-1:0] rom_addr,
  input  logic [WordSize-1:0]    rom_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam int CntW = (AccessCycles > 1) ? $clog2(AccessCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(AccessCycles - 1);

  state_t                 state_q, state_d;
  owner_t                 owner_q, owner_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   rom_ce_bar_q, rom_ce_bar_d;
  logic [AddressSize-1:0] rom_addr_q, rom_addr_d;
  logic [WordSize-1:0]    rd_data_q, rd_data_d;
  logic                   cpu_gnt_q, cpu_gnt_d;
  logic                   dbg_gnt_q, dbg_gnt_d;
  logic                   cpu_valid_q, cpu_valid_d;
  logic                   dbg_valid_q, dbg_valid_d;
  owner_t                 winner;
`ifdef ROM_ARB_RR_EN
  owner_t                 rr_last_q, rr_last_d;
`endif

  // Select the requester that wins if a grant is issued this cycle
  always_comb begin
    winner = OWN_CPU;
`ifdef ROM_ARB_RR_EN
    if (cpu_req && dbg_req) begin
      winner = (rr_last_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (dbg_req) begin
      winner = OWN_DBG;
    end
`else
    if (!cpu_req && dbg_req) begin
      winner = OWN_DBG;
    end
`endif
  end

  // Next-state and registered-output logic for the access sequencer
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    rom_ce_bar_d = 1'b1;
    rom_addr_d   = rom_addr_q;
    rd_data_d    = rd_data_q;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_valid_d  = 1'b0;
    dbg_valid_d  = 1'b0;
`ifdef ROM_ARB_RR_EN
    rr_last_d    = rr_last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          state_d      = S_ACCESS;
          owner_d      = winner;
          cnt_d        = '0;
          rom_ce_bar_d = 1'b0;
          rom_addr_d   = (winner == OWN_CPU) ? cpu_addr : dbg_addr;
          cpu_gnt_d    = (winner == OWN_CPU);
          dbg_gnt_d    = (winner == OWN_DBG);
`ifdef ROM_ARB_RR_EN
          rr_last_d    = winner;
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q == CntLast) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          rd_data_d   = rom_data;
          cpu_valid_d = (owner_q == OWN_CPU);
          dbg_valid_d = (owner_q == OWN_DBG);
        end else begin
          cnt_d        = cnt_q + CntW'(1);
          rom_ce_bar_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by clr
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CPU;
      cnt_q        <= '0;
      rom_ce_bar_q <= 1'b1;
      rom_addr_q   <= '0;
      rd_data_q    <= '0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_valid_q  <= 1'b0;
      dbg_valid_q  <= 1'b0;
`ifdef ROM_ARB_RR_EN
      rr_last_q    <= OWN_DBG;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      rom_ce_bar_q <= rom_ce_bar_d;
      rom_addr_q   <= rom_addr_d;
      rd_data_q    <= rd_data_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_valid_q  <= cpu_valid_d;
      dbg_valid_q  <= dbg_valid_d;
`ifdef ROM_ARB_RR_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign dbg_gnt    = dbg_gnt_q;
  assign cpu_valid  = cpu_valid_q;
  assign dbg_valid  = dbg_valid_q;
  assign rd_data    = rd_data_q;
  assign rom_ce_bar = rom_ce_bar_q;
  assign rom_addr   = rom_addr_q;

endmodule
